// File: rtl/score_overlay_pkg.sv
// Shared types and constants for the score overlay: register map, reset defaults,
// BCD nibble type and the 8x8 digit font (row bit 7 is the leftmost glyph column).
package score_overlay_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic suppress;
        logic enable;
    } ctrl_t;

    localparam logic [3:0] ADDR_SCORE = 4'd0;
    localparam logic [3:0] ADDR_X     = 4'd1;
    localparam logic [3:0] ADDR_Y     = 4'd2;
    localparam logic [3:0] ADDR_CTRL  = 4'd3;
    localparam logic [3:0] ADDR_INC   = 4'd4;
    localparam logic [3:0] ADDR_CLR   = 4'd5;
    localparam logic [3:0] ADDR_HICLR = 4'd6;

    localparam logic [10:0] X_DEFAULT    = 11'd8;
    localparam logic [9:0]  Y_DEFAULT    = 10'd8;
    localparam ctrl_t       CTRL_DEFAULT = '{suppress: 1'b0, enable: 1'b1};

    // Any code above 9 renders as an empty glyph; used for suppressed leading zeros.
    localparam bcd_t BLANK_CODE = 4'hF;

    localparam logic [0:9][0:7][7:0] FONT = {
        64'h3C666E7666663C00,  // 0
        64'h183818181818_7E00, // 1
        64'h3C66060C30607E00,  // 2
        64'h3C66061C06663C00,  // 3
        64'h0C1C3C6C7E0C0C00,  // 4
        64'h7E607C0606663C00,  // 5
        64'h3C607C6666663C00,  // 6
        64'h7E060C1830303000,  // 7
        64'h3C66663C66663C00,  // 8
        64'h3C66663E060C3800   // 9
    };

    function automatic bcd_t sat_digit(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

endpackage

// File: rtl/score_overlay_if.sv
// Register bus for the score overlay: single-cycle writes when chipselect and write are high.
interface score_overlay_if;

    logic        chipselect;
    logic        write;
    logic [3:0]  address;
    logic [31:0] writedata;

    modport master (output chipselect, output write, output address, output writedata);
    modport slave  (input  chipselect, input  write, input  address, input  writedata);

endinterface

// File: rtl/score_glyph_rom.sv
// Registered font lookup: one glyph bit per cycle, gated by the caller's enable.
module score_glyph_rom
    import score_overlay_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  bcd_t       digit_i,
    input  logic [2:0] row_i,
    input  logic [2:0] col_i,
    input  logic       en_i,
    output logic       pix_o
);

    logic [7:0] row_bits;
    logic       pix_q;

    always_comb begin
        // NOTE: default first, otherwise the codes above 9 would infer a latch.
        row_bits = 8'h00;
        if (digit_i <= 4'd9) row_bits = FONT[digit_i][row_i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pix_q <= 1'b0;
        else          pix_q <= en_i & row_bits[~col_i];
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/score_overlay.sv
// BCD score counter with a tear-free glyph overlay on a raster stream.
// Define SCORE_OVERLAY_HISCORE_EN to add the high-score register.
module score_overlay
    import score_overlay_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter int          SCALE_LOG2 = 1,
    parameter logic [23:0] FG_RGB     = 24'hFFFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    score_overlay_if.slave          bus,
    input  logic [10:0]             hcount,
    input  logic [9:0]              vcount,
    input  logic                    inc_pulse,
    input  logic                    clr_pulse,
    output logic                    pix_on,
    output logic [23:0]             pix_rgb,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] hiscore_bcd
);

    localparam int            SW        = 4 * NUM_DIGITS;
    localparam int            GLYPH     = 8 << SCALE_LOG2;
    localparam int            WIDTH     = NUM_DIGITS * GLYPH;
    localparam logic [SW-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    logic bus_wr, do_clr, do_wr, do_inc;
    assign bus_wr = bus.chipselect & bus.write;
    assign do_clr = clr_pulse | (bus_wr && bus.address == ADDR_CLR);
    assign do_wr  = bus_wr && bus.address == ADDR_SCORE;
    assign do_inc = inc_pulse | (bus_wr && bus.address == ADDR_INC);

    logic [SW-1:0] score_q, score_d, score_inc, score_wr;
    logic          ovf_q, ovf_d, carry;
    logic [10:0]   x_q;
    logic [9:0]    y_q;
    ctrl_t         ctrl_q;

    always_comb begin
        // NOTE: blocking here so the carry ripples through every digit in one evaluation.
        score_inc = score_q;
        score_wr  = '0;
        carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            score_wr[4*i +: 4] = sat_digit(bus.writedata[4*i +: 4]);
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        score_d = score_q;
        ovf_d   = ovf_q;
        if (do_clr) begin
            score_d = '0;
            ovf_d   = 1'b0;
        end else if (do_wr) begin
            score_d = score_wr;
        end else if (do_inc) begin
            if (score_q == ALL_NINES) ovf_d   = 1'b1;
            else                      score_d = score_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_q <= '0;
            ovf_q   <= 1'b0;
            x_q     <= X_DEFAULT;
            y_q     <= Y_DEFAULT;
            ctrl_q  <= CTRL_DEFAULT;
        end else begin
            score_q <= score_d;
            ovf_q   <= ovf_d;
            if (bus_wr) begin
                case (bus.address)
                    ADDR_X:    x_q    <= bus.writedata[10:0];
                    ADDR_Y:    y_q    <= bus.writedata[9:0];
                    ADDR_CTRL: ctrl_q <= ctrl_t'(bus.writedata[1:0]);
                    default:   ;
                endcase
            end
        end
    end

`ifdef SCORE_OVERLAY_HISCORE_EN
    logic [SW-1:0] hiscore_q;

    // Valid BCD orders the same as plain binary, MSD first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               hiscore_q <= '0;
        else if (bus_wr && bus.address == ADDR_HICLR) hiscore_q <= '0;
        else if (do_clr && score_q > hiscore_q)     hiscore_q <= score_q;
    end

    assign hiscore_bcd = hiscore_q;
`else
    assign hiscore_bcd = '0;
`endif

    // Frame shadows; frame_valid_q holds rendering off until the first snapshot after reset.
    logic [SW-1:0] snap_q;
    logic [10:0]   x_sh_q;
    logic [9:0]    y_sh_q;
    ctrl_t         ctrl_sh_q;
    logic          frame_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q        <= '0;
            x_sh_q        <= X_DEFAULT;
            y_sh_q        <= Y_DEFAULT;
            ctrl_sh_q     <= CTRL_DEFAULT;
            frame_valid_q <= 1'b0;
        end else if (hcount == 11'd0 && vcount == 10'd0) begin
            snap_q        <= score_q;
            x_sh_q        <= x_q;
            y_sh_q        <= y_q;
            ctrl_sh_q     <= ctrl_q;
            frame_valid_q <= 1'b1;
        end
    end

    logic [12:0] h_ext, x_lo, x_hi, dx, digit_idx;
    logic [11:0] v_ext, y_lo, y_hi, dy;
    logic        in_region;

    assign h_ext     = {2'b00, hcount};
    assign x_lo      = {2'b00, x_sh_q};
    assign x_hi      = x_lo + 13'(WIDTH);
    assign v_ext     = {2'b00, vcount};
    assign y_lo      = {2'b00, y_sh_q};
    assign y_hi      = y_lo + 12'(GLYPH);
    assign in_region = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);
    assign dx        = h_ext - x_lo;
    assign dy        = v_ext - y_lo;
    assign digit_idx = dx >> (3 + SCALE_LOG2);

    logic [NUM_DIGITS-1:0] blank;
    logic                  lead;
    bcd_t                  sel_digit;

    always_comb begin
        lead      = 1'b1;
        blank     = '0;
        sel_digit = BLANK_CODE;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead     = lead & (snap_q[4*i +: 4] == 4'd0);
            blank[i] = lead & ctrl_sh_q.suppress & (i != 0);
            if (digit_idx == 13'(NUM_DIGITS - 1 - i))
                sel_digit = blank[i] ? BLANK_CODE : snap_q[4*i +: 4];
        end
    end

    logic       s1_in_q;
    bcd_t       s1_digit_q;
    logic [2:0] s1_row_q, s1_col_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_in_q    <= 1'b0;
            s1_digit_q <= '0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
        end else begin
            s1_in_q    <= in_region;
            s1_digit_q <= sel_digit;
            s1_row_q   <= 3'(dy >> SCALE_LOG2);
            s1_col_q   <= 3'(dx >> SCALE_LOG2);
        end
    end

    score_glyph_rom u_glyph_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .digit_i (s1_digit_q),
        .row_i   (s1_row_q),
        .col_i   (s1_col_q),
        .en_i    (s1_in_q & ctrl_sh_q.enable & frame_valid_q),
        .pix_o   (pix_on)
    );

    assign pix_rgb   = pix_on ? FG_RGB : 24'h000000;
    assign score_bcd = score_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: counter, bus priority, snapshot rendering and reset.
module tb_score_overlay;

    localparam int H_TOTAL = 80;
    localparam int V_TOTAL = 28;
    localparam int NPIX    = H_TOTAL * V_TOTAL;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        inc_pulse, clr_pulse;
    logic        pix_on, overflow;
    logic [23:0] pix_rgb;
    logic [15:0] score_bcd, hiscore_bcd;

    score_overlay_if bus ();

    score_overlay #(.NUM_DIGITS(4), .SCALE_LOG2(1), .FG_RGB(24'hFFFFFF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .hcount      (hcount),
        .vcount      (vcount),
        .inc_pulse   (inc_pulse),
        .clr_pulse   (clr_pulse),
        .pix_on      (pix_on),
        .pix_rgb     (pix_rgb),
        .score_bcd   (score_bcd),
        .overflow    (overflow),
        .hiscore_bcd (hiscore_bcd)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    bit lit_map [NPIX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = addr; bus.writedata = data;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic pulse(input bit inc, input bit clr);
        @(negedge clk);
        inc_pulse = inc; clr_pulse = clr;
        @(negedge clk);
        inc_pulse = 1'b0; clr_pulse = 1'b0;
    endtask

    // Output seen at a falling edge belongs to the coordinate driven two falling edges earlier.
    task automatic scan_frame(input int wr_at, input logic [31:0] wr_val);
        for (int n = 0; n < NPIX + 2; n++) begin
            @(negedge clk);
            if (n >= 2) lit_map[n-2] = pix_on;
            if (n < NPIX) begin
                hcount = 11'(n % H_TOTAL);
                vcount = 10'(n / H_TOTAL);
            end else begin
                hcount = 11'd1000;
                vcount = 10'd500;
            end
            bus.chipselect = (n == wr_at);
            bus.write      = (n == wr_at);
            bus.address    = 4'd0;
            bus.writedata  = wr_val;
        end
    endtask

    function automatic int lit_in_cols(input int hlo, input int hhi);
        int c = 0;
        for (int n = 0; n < NPIX; n++)
            if ((n % H_TOTAL) >= hlo && (n % H_TOTAL) <= hhi && lit_map[n]) c++;
        return c;
    endfunction

    function automatic int first_lit();
        for (int n = 0; n < NPIX; n++) if (lit_map[n]) return n;
        return -1;
    endfunction

    function automatic bit lit(input int h, input int v);
        return lit_map[v * H_TOTAL + h];
    endfunction

    initial begin
        hcount = 11'd1000; vcount = 10'd500;
        inc_pulse = 1'b0; clr_pulse = 1'b0;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = 4'd0; bus.writedata = 32'd0;

        #2 reset_n = 1'b0;
        #1;
        check("rst_score", score_bcd, 16'h0000);
        check("rst_overflow", overflow, 1'b0);
        check("rst_hiscore", hiscore_bcd, 16'h0000);
        check("rst_pix_on", pix_on, 1'b0);
        check("rst_pix_rgb", pix_rgb, 24'h000000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        repeat (10) pulse(1'b1, 1'b0);
        check("inc10_score", score_bcd, 16'h0010);
        check("inc10_overflow", overflow, 1'b0);

        bus_write(4'd0, 32'h9998);
        check("wr_9998", score_bcd, 16'h9998);
        pulse(1'b1, 1'b0);
        check("inc_to_9999", score_bcd, 16'h9999);
        check("no_ovf_yet", overflow, 1'b0);
        bus_write(4'd4, 32'h0);
        check("sat_score", score_bcd, 16'h9999);
        check("sat_ovf", overflow, 1'b1);
        pulse(1'b1, 1'b0);
        check("sat_score_again", score_bcd, 16'h9999);
        check("ovf_sticky", overflow, 1'b1);
        pulse(1'b0, 1'b1);
        check("clr_score", score_bcd, 16'h0000);
        check("clr_ovf", overflow, 1'b0);

        bus_write(4'd0, 32'hABC5);
        check("nibble_clamp", score_bcd, 16'h9995);

        @(negedge clk);
        clr_pulse = 1'b1; inc_pulse = 1'b1;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 4'd0; bus.writedata = 32'h1234;
        @(negedge clk);
        clr_pulse = 1'b0; inc_pulse = 1'b0; bus.chipselect = 1'b0; bus.write = 1'b0;
        check("clr_beats_all", score_bcd, 16'h0000);

        @(negedge clk);
        inc_pulse = 1'b1;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 4'd0; bus.writedata = 32'h1234;
        @(negedge clk);
        inc_pulse = 1'b0; bus.chipselect = 1'b0; bus.write = 1'b0;
        check("wr_beats_inc", score_bcd, 16'h1234);

        @(negedge clk);
        inc_pulse = 1'b1;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 4'd4;
        @(negedge clk);
        inc_pulse = 1'b0; bus.chipselect = 1'b0; bus.write = 1'b0;
        check("dual_inc_once", score_bcd, 16'h1235);

        bus_write(4'd0, 32'h0199);
        pulse(1'b1, 1'b0);
        check("ripple_carry", score_bcd, 16'h0200);
        bus_write(4'd7, 32'h0000_0005);
        check("addr7_ignored", score_bcd, 16'h0200);

`ifdef SCORE_OVERLAY_HISCORE_EN
        bus_write(4'd0, 32'h0042);
        pulse(1'b0, 1'b1);
        check("hiscore_load", hiscore_bcd, 16'h0042);
        bus_write(4'd0, 32'h0017);
        pulse(1'b0, 1'b1);
        check("hiscore_keep", hiscore_bcd, 16'h0042);
        bus_write(4'd6, 32'h0);
        check("hiscore_zeroed", hiscore_bcd, 16'h0000);
`else
        bus_write(4'd0, 32'h0042);
        pulse(1'b0, 1'b1);
        check("hiscore_const0", hiscore_bcd, 16'h0000);
`endif
        bus_write(4'd0, 32'h0055);
        bus_write(4'd6, 32'h0);
        check("addr6_keeps_score", score_bcd, 16'h0055);

        // Score 0007, x=y=8, enable+suppress: only the rightmost glyph (hcount 56..71) lights.
        bus_write(4'd0, 32'h0007);
        bus_write(4'd1, 32'd8);
        bus_write(4'd2, 32'd8);
        bus_write(4'd3, 32'h3);
        scan_frame(2 * H_TOTAL, 32'h0008);
        check("f1_outside_lit", lit_in_cols(0, 55) + lit_in_cols(72, H_TOTAL - 1), 0);
        check("f1_total_lit", lit_in_cols(0, H_TOTAL - 1), 72);
        check("f1_first_lit", first_lit(), 8 * H_TOTAL + 58);
        check("f1_seven_r3c2", lit(60, 14), 1'b0);
        check("f1_lead_zero_off", lit(12, 8), 1'b0);
        check("f1_live_score", score_bcd, 16'h0008);

        scan_frame(-1, 32'h0);
        check("f2_eight_r3c2", lit(60, 14), 1'b1);
        check("f2_total_lit", lit_in_cols(0, H_TOTAL - 1), 112);
        check("f2_outside_lit", lit_in_cols(0, 55) + lit_in_cols(72, H_TOTAL - 1), 0);

        bus_write(4'd3, 32'h1);
        scan_frame(-1, 32'h0);
        check("f3_lead_zero_on", lit(12, 8), 1'b1);
        check("f3_eight_r0c2", lit(60, 8), 1'b1);

        bus_write(4'd3, 32'h0);
        scan_frame(-1, 32'h0);
        check("f4_disabled", lit_in_cols(0, H_TOTAL - 1), 0);
        check("f4_counting", score_bcd, 16'h0008);

        bus_write(4'd3, 32'h1);
        @(negedge clk); hcount = 11'd0;  vcount = 10'd0;
        @(negedge clk); hcount = 11'd60; vcount = 10'd8;
        @(negedge clk);
        check("lat_1cyc_dark", pix_on, 1'b0);
        @(negedge clk);
        check("lat_2cyc_lit", pix_on, 1'b1);
        check("lit_rgb", pix_rgb, 24'hFFFFFF);

        #2 reset_n = 1'b0;
        #1;
        check("async_rst_pix", pix_on, 1'b0);
        check("async_rst_rgb", pix_rgb, 24'h000000);
        check("async_rst_score", score_bcd, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("dark_until_snap", pix_on, 1'b0);
        @(negedge clk); hcount = 11'd0;  vcount = 10'd0;
        @(negedge clk); hcount = 11'd60; vcount = 10'd8;
        repeat (2) @(negedge clk);
        check("resume_after_snap", pix_on, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/score_overlay.md
SCORE_OVERLAY -- requirements
Module: score_overlay

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of decimal digits displayed (legal 1..8).
REQ-002 Parameter SCALE_LOG2, default 1, glyph magnification as a power of two (legal 0..2); each glyph is 8x8 source pixels.
REQ-003 Parameter FG_RGB, default 24'hFFFFFF, foreground colour driven on lit glyph pixels.
REQ-004 clk  in  1  single system clock; every register is clocked on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 chipselect  in  1  bus select.
REQ-007 write  in  1  bus write strobe; a write occurs when chipselect and write are both 1.
REQ-008 address  in  4  register index.
REQ-009 writedata  in  32  write data.
REQ-010 hcount  in  11  current raster column.
REQ-011 vcount  in  10  current raster line.
REQ-012 inc_pulse  in  1  game-logic increment request, one per high cycle.
REQ-013 clr_pulse  in  1  game-logic clear request.
REQ-014 pix_on  out  1  lit glyph pixel; delayed 2 cycles relative to hcount/vcount.
REQ-015 pix_rgb  out  24  FG_RGB when pix_on is 1, otherwise 0.
REQ-016 score_bcd  out  4*NUM_DIGITS  live BCD score; nibble 0 is the least significant digit.
REQ-017 overflow  out  1  sticky saturation flag.
REQ-018 hiscore_bcd  out  4*NUM_DIGITS  best score; see REQ-036.

Function
REQ-019 Register map:
- 0 = score (writedata BCD nibbles; each nibble >9 is stored as 9).
- 1 = x position (11 b).
- 2 = y position (10 b).
- 3 = control: bit0 enable, bit1 leading-zero suppress.
- 4 = increment by one.
- 5 = clear.
- Other addresses are ignored.
REQ-020 An increment (inc_pulse or a write to address 4) adds 1 in BCD with ripple carry across all digits in one cycle.
REQ-021 An increment issued at all-9s leaves the score at all-9s and sets overflow.
REQ-022 A clear (clr_pulse or a write to address 5) sets the score to 0 and overflow to 0.
REQ-023 Same-cycle priority: clear > score write > increment; the losing requests are dropped, not queued.
REQ-024 inc_pulse and a bus increment in the same cycle count as one increment.
REQ-025 The display snapshot register loads score_bcd when hcount==0 and vcount==0; rendering uses only the snapshot, so there is no mid-frame tearing.
REQ-026 x, y and control are also sampled into shadow registers at the REQ-025 instant.
REQ-027 Region: W = NUM_DIGITS*(8<<SCALE_LOG2) columns starting at x; H = 8<<SCALE_LOG2 lines starting at y.
REQ-028 Pixels are inside the region when x <= hcount < x+W and y <= vcount < y+H; all comparisons are unsigned and at least 12 bits wide, with no wrap.
REQ-029 Glyph addressing:
- digit index = (hcount-x)>>(3+SCALE_LOG2), with index 0 the leftmost (most significant) digit.
- glyph column = ((hcount-x)>>SCALE_LOG2)&7.
- glyph row = ((vcount-y)>>SCALE_LOG2)&7.
REQ-030 Pipeline:
- Stage 1 registers the in-region flag, the selected digit value and the row/column.
- Stage 2 registers the glyph bit ANDed with the in-region flag and with enable.
- pix_on is the stage-2 output.
REQ-031 With suppress=1, a digit that is zero with only zeros to its left renders unlit; the least significant digit always renders.
REQ-032 With enable=0, pix_on is 0; counting continues.

Reset
REQ-033 On reset_n low, without waiting for a clock edge:
- score, snapshot, overflow and hiscore = 0.
- x = 8, y = 8.
- control = 2'b01.
- pipeline registers and pix_on = 0; pix_rgb = 0.
REQ-034 Reset asserted mid-frame forces pix_on to 0 immediately; rendering resumes at the next REQ-025 snapshot instant after release.

Configuration
REQ-035 Macro SCORE_OVERLAY_HISCORE_EN enables the high-score feature.
REQ-036 With the macro defined:
- At every clear, hiscore loads the pre-clear score if that score is greater than hiscore (BCD magnitude compare, MSD first).
- A write to address 6 zeroes hiscore.
REQ-037 Without the macro, hiscore_bcd is constant 0, address 6 is ignored, and no compare logic is synthesised.

Structure
REQ-038 Package score_overlay_pkg holds:
- register address constants.
- the 8x8 digit font table for 0-9.
- default x/y/control constants.
- the bcd_t nibble type.
REQ-039 A single sub-module, score_glyph_rom (registered, 1-cycle read, inputs digit and row/column, output 1 bit), provides pipeline stage 2.

Verification
REQ-040 Reset, then 10 inc_pulse -> score_bcd=16'h0010, overflow=0.
REQ-041 Write address 0 = 16'h9998, then 3 increments -> 16'h9999 and overflow=1; a following clr_pulse -> 0 and overflow=0.
REQ-042 Same cycle: clr_pulse, inc_pulse and a score write of 16'h1234 -> score=0.
REQ-043 NUM_DIGITS=4, SCALE_LOG2=1, x=8, y=8, score=16'h0007, suppress=1 -> every scanline lit only within hcount 56..71.
REQ-044 pix_on asserts exactly 2 cycles after the first lit (hcount,vcount).
REQ-045 score write mid-frame -> display unchanged until the next (0,0) snapshot.
REQ-046 With SCORE_OVERLAY_HISCORE_EN: score 16'h0042 then clear -> hiscore=16'h0042; score 16'h0017 then clear -> hiscore stays 16'h0042.
